if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 16-bit pipeline. It owns the program counter, issues word reads to instruction memory over a request/valid handshake, and loads the IF/ID pipeline register that feeds decode and the hazard detection unit. It obeys `pc_write`/`if_id_write` from hazard detection, redirects on taken branches from EX, and stops fetching after a HLT (opcode 4'b1111).

## Interface
- `ADDR_W`, 16, PC and instruction-memory address width (word addressed).
- `RESET_PC`, 16'h0000, PC value after reset.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_write`  in  1  PC may advance (from hazard detection).
- `if_id_write`  in  1  IF/ID may load (from hazard detection).
- `branch_taken`  in  1  redirect request from EX; one-cycle pulse.
- `branch_target`  in  ADDR_W  redirect PC; valid when `branch_taken`=1.
- `imem_req`  out  1  read request; Moore output, high only in REQ.
- `imem_addr`  out  ADDR_W  equals current PC.
- `imem_valid`  in  1  read data valid; at least 1 cycle after `imem_req`.
- `imem_rdata`  in  16  instruction word.
- `if_id_instr`  out  16  IF/ID instruction.
- `if_id_pc_plus1`  out  ADDR_W  IF/ID PC+1 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `halted`  out  1  high in HALT.

## Operation
- States: START, REQ, WAIT, HOLD, DRAIN, HALT. Reset state is START.
- START -> REQ unconditionally. This guarantees `imem_req`=0 during reset and on the first cycle after it.
- REQ: `imem_req`=1 and `imem_addr`=PC for exactly one cycle, then -> WAIT.
- WAIT, with `imem_valid`=1 ("accept"):
  - If `if_id_write`=1 and `pc_write`=1: load IF/ID as `instr`=`imem_rdata`, `pc_plus1`=PC+1, `valid`=1. Set PC<=PC+1.
  - Then -> HALT if `imem_rdata[15:12]`==4'b1111, otherwise -> REQ.
  - If either `if_id_write` or `pc_write` is 0: capture the word into a one-entry hold buffer and -> HOLD. IF/ID is unchanged.
- HOLD: on the first cycle with `if_id_write`=1 and `pc_write`=1, load IF/ID from the buffer and advance PC with the same rules as WAIT. Then -> HALT or REQ.
- HALT: no requests. IF/ID is frozen. Leave only on `branch_taken` or reset.
- Flush (`branch_taken`=1) overrides everything, in any state:
  - PC<=`branch_target`.
  - IF/ID<= bubble (`instr`=16'h0000, `valid`=0, `pc_plus1`=0).
  - The hold buffer is discarded.
  - Next state: DRAIN if a request is outstanding (in REQ, or in WAIT without `imem_valid` that cycle); otherwise REQ.
- A flush in the same cycle as an accept discards the accepted word and goes to REQ.
- DRAIN: wait for `imem_valid` and discard that word. Then -> REQ. A further `branch_taken` in DRAIN updates PC and stays in DRAIN.
- `if_id_write`=0 holds IF/ID; it never inserts a bubble. Bubbles come only from flush and reset.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 = 16'h0000, with no flag.

## Timing
- Reset (async, while `rst_n`=0):
  - PC=`RESET_PC`.
  - `if_id_instr`=16'h0000, `if_id_pc_plus1`=0, `if_id_valid`=0.
  - `halted`=0, `imem_req`=0, hold buffer empty.
- Reset asserted mid-transaction abandons it. A late `imem_valid` arriving in START or REQ is ignored.
- Fetch latency: request at cycle t, valid at t+k (k>=1), IF/ID visible at t+k+1, next request at t+k+1.
- Best-case throughput is one instruction per 2 cycles.
- `imem_valid` outside WAIT/DRAIN is ignored.
- All outputs except `imem_req`/`imem_addr` are registered. `imem_addr` is the PC register.

## Test plan
- Reset release, 1-cycle memory returning 0x1234, 0x5678 at addresses 0, 1 -> `imem_req` first high in cycle 2. IF/ID shows {0x1234, pc_plus1=1, valid=1}, then {0x5678, 2, 1}, two cycles apart.
- Hazard stall: drop `if_id_write`/`pc_write` for 3 cycles coincident with an accept -> IF/ID unchanged for 3 cycles, no new `imem_req`. On release, the buffered word loads and PC increments by exactly 1.
- HLT: word 0xF000 fetched at PC 5 -> IF/ID = 0xF000, `halted`=1, PC=6, no further `imem_req` for 20 cycles.
- Branch in WAIT, 4-cycle memory: `branch_taken` with target 0x0040 while a request is outstanding -> IF/ID bubble, DRAIN discards the returned word, next `imem_addr`=0x0040.
- Wrap: `RESET_PC`=16'hFFFF, fetch one word -> `if_id_pc_plus1`=0, next `imem_addr`=0x0000.
- Mid-fetch reset: assert `rst_n`=0 in WAIT, then pulse `imem_valid` after release during START -> the word is ignored, first fetch is at `RESET_PC`.

Source files
------------

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 16-bit pipeline.
//
// Owns the program counter, issues one word read at a time to instruction
// memory, and loads the IF/ID pipeline register. Obeys stall requests from
// hazard detection, redirects on taken branches from EX, and stops fetching
// after a HLT instruction (opcode 4'b1111).
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   pc_write         PC may advance (hazard detection)
//   if_id_write      IF/ID may load (hazard detection)
//   branch_taken     one-cycle redirect pulse from EX
//   branch_target    redirect PC, valid with branch_taken
//   imem_req         read request, high only while in REQ
//   imem_addr        read address (the PC register)
//   imem_valid       read data valid, at least one cycle after imem_req
//   imem_rdata       instruction word
//   if_id_instr      IF/ID instruction
//   if_id_pc_plus1   IF/ID PC+1 of that instruction
//   if_id_valid      IF/ID holds a real instruction (0 = bubble)
//   halted           high while halted after a HLT
//
// Handshake: a request is a single-cycle imem_req pulse with imem_addr. The
// stage then waits (WAIT) for exactly one imem_valid cycle carrying the word.
// Only one request is ever outstanding; imem_valid seen outside WAIT/DRAIN is
// ignored.
// -----------------------------------------------------------------------------
module if_stage #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_write,
    input  logic              if_id_write,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc_plus1,
    output logic              if_id_valid,
    output logic              halted
);

    typedef enum logic [2:0] {
        START = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4,
        HALT  = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       hold_buf;

    logic [ADDR_W-1:0] pc_plus1;
    logic              advance;
    logic              outstanding;
    logic              do_load;
    logic [15:0]       load_word;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_plus1 = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    assign advance  = pc_write & if_id_write;

    // A memory read is still in flight if we are issuing it now or are
    // waiting for it and it does not complete this cycle. A flush in that
    // situation must drain the stale word before issuing a new request.
    assign outstanding = (state == REQ) |
                         (((state == WAIT) | (state == DRAIN)) & ~imem_valid);

    assign do_load   = advance & (((state == WAIT) & imem_valid) | (state == HOLD));
    assign load_word = (state == HOLD) ? hold_buf : imem_rdata;

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= START;
            pc             <= RESET_PC;
            hold_buf       <= '0;
            if_id_instr    <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else if (branch_taken) begin
            // Flush wins over everything, including a same-cycle accept.
            pc             <= branch_target;
            hold_buf       <= '0;
            if_id_instr    <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
            state          <= outstanding ? DRAIN : REQ;
        end else if (do_load) begin
            if_id_instr    <= load_word;
            if_id_pc_plus1 <= pc_plus1;
            if_id_valid    <= 1'b1;
            pc             <= pc_plus1;
            if (load_word[15:12] == 4'b1111) begin
                state  <= HALT;
                halted <= 1'b1;
            end else begin
                state  <= REQ;
            end
        end else begin
            case (state)
                START: state <= REQ;
                REQ:   state <= WAIT;
                WAIT: begin
                    // Word arrived while stalled: park it until the stall lifts.
                    if (imem_valid) begin
                        hold_buf <= imem_rdata;
                        state    <= HOLD;
                    end
                end
                HOLD:  state <= HOLD;
                DRAIN: begin
                    if (imem_valid) state <= REQ;
                end
                HALT:  state <= HALT;
                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A memory responder answers each request after a chosen latency from a
// small ROM. The expected IF/ID stream is derived from the program-order
// rules (fetch rom[pc] at pc, advance by one, stop at HLT, restart at branch
// target, bubble on flush) and pushed into exp_q before the stimulus that
// causes it. A monitor pops one entry every time the IF/ID contents change.
// A second instance with RESET_PC=16'hFFFF covers address wrap.
// -----------------------------------------------------------------------------
module tb_if_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- DUT signals ----------------
    logic        pc_write, if_id_write, branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;

    logic        resp_valid, inj_valid;
    logic [15:0] resp_rdata, inj_data;
    assign imem_valid = resp_valid | inj_valid;
    assign imem_rdata = inj_valid ? inj_data : resp_rdata;

    // wrap instance signals
    logic        w_one, w_zero;
    logic [15:0] w_target;
    assign w_one    = 1'b1;
    assign w_zero   = 1'b0;
    assign w_target = 16'h0000;
    logic        w_req, w_valid, w_if_id_valid, w_halted;
    logic [15:0] w_addr, w_rdata, w_if_id_instr, w_if_id_pc_plus1;

    if_stage #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc_plus1(if_id_pc_plus1),
        .if_id_valid(if_id_valid), .halted(halted)
    );

    if_stage #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .pc_write(w_one), .if_id_write(w_one),
        .branch_taken(w_zero), .branch_target(w_target),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_valid(w_valid), .imem_rdata(w_rdata),
        .if_id_instr(w_if_id_instr), .if_id_pc_plus1(w_if_id_pc_plus1),
        .if_id_valid(w_if_id_valid), .halted(w_halted)
    );

    // ---------------- shared state ----------------
    logic [15:0] rom [0:255];
    int          mem_lat;       // 0 = random 1..4 per request
    logic        rand_haz;
    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];      // {valid, pc_plus1, instr}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rand_word();
        return {4'($urandom_range(0, 14)), 12'($urandom_range(0, 4095))};
    endfunction

    task automatic push_exp(input logic v, input logic [15:0] pc1, input logic [15:0] instr);
        exp_q.push_back({v, pc1, instr});
    endtask

    // Program-order fetch of n words starting at start.
    task automatic push_stream(input logic [15:0] start, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 16'(i);
            exp_q.push_back({1'b1, a + 16'd1, rom[a[7:0]]});
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int          cnt;
        logic [15:0] pend_addr;
        logic        w_pend;
        logic [7:0]  w_pend_addr;
        cnt = 0; pend_addr = '0; w_pend = 1'b0; w_pend_addr = '0;
        resp_valid = 1'b0; resp_rdata = '0;
        w_valid = 1'b0; w_rdata = '0;
        forever begin
            @(negedge clk);
            resp_valid = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    resp_valid = 1'b1;
                    resp_rdata = rom[pend_addr[7:0]];
                end
            end else if (imem_req) begin
                pend_addr = imem_addr;
                cnt = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
            end
            // wrap instance: fixed one-cycle memory
            w_valid     = w_pend;
            w_rdata     = rom[w_pend_addr];
            w_pend      = w_req && rst_n;
            w_pend_addr = w_addr[7:0];
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [32:0] prev, cur, exp;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = '0;
            end else begin
                cur = {if_id_valid, if_id_pc_plus1, if_id_instr};
                if (cur !== prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL if_id_unexpected actual=%0h expected=none", cur);
                    end else begin
                        exp = exp_q.pop_front();
                        check("if_id_load", cur, exp);
                    end
                    prev = cur;
                end
                if (halted) check("halt_no_req", imem_req, 1'b0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        if (rand_haz) begin
            pc_write    = ($urandom_range(0, 3) != 0);
            if_id_write = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic branch(input logic [15:0] target);
        branch_taken  = 1'b1;
        branch_target = target;
        tick();
        branch_taken  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!(halted && exp_q.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        check(name, (halted && exp_q.size() == 0), 1'b1);
    endtask

    task automatic wait_req(input int budget, input string name);
        int n;
        n = 0;
        while (!imem_req && n < budget) begin
            tick();
            n++;
        end
        check(name, imem_req, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          n_req, n;
        logic [15:0] s;
        int          len;
        rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
        branch_taken = 1'b0; branch_target = '0;
        inj_valid = 1'b0; inj_data = '0;
        mem_lat = 1; rand_haz = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = rand_word();
        rom[0] = 16'h1234;
        rom[1] = 16'h5678;
        rom[5] = 16'hF000;
        rom[8'h44] = 16'hF000;
        rom[8'h33] = 16'hF000;

        repeat (3) @(negedge clk);
        check("rst_instr", if_id_instr, 16'h0000);
        check("rst_pc_plus1", if_id_pc_plus1, 16'h0000);
        check("rst_valid", if_id_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 16'h0000);

        // ---- basic fetch, stall, HLT ----
        push_stream(16'h0000, 6);
        rst_n = 1'b1;                 // START during the coming cycle
        tick();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 16'h0000);
        tick(); tick();
        check("load0_instr", if_id_instr, 16'h1234);
        check("load0_pc1", if_id_pc_plus1, 16'h0001);
        check("wrap_pc1", w_if_id_pc_plus1, 16'h0000);
        check("wrap_instr", w_if_id_instr, rom[255]);
        check("wrap_next_addr", w_addr, 16'h0000);
        tick(); tick();
        check("load1_instr", if_id_instr, 16'h5678);
        check("load1_pc1", if_id_pc_plus1, 16'h0002);
        tick();                       // word for address 2 is on the bus now
        pc_write = 1'b0; if_id_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_pc1", if_id_pc_plus1, 16'h0002);
            check("stall_no_req", imem_req, 1'b0);
        end
        pc_write = 1'b1; if_id_write = 1'b1;
        tick();
        check("release_pc1", if_id_pc_plus1, 16'h0003);
        check("release_instr", if_id_instr, rom[2]);
        check("release_addr", imem_addr, 16'h0003);
        wait_done(200, "halt_reached");
        check("halt_instr", if_id_instr, 16'hF000);
        check("halt_pc1", if_id_pc_plus1, 16'h0006);
        check("halt_pc", imem_addr, 16'h0006);
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req) n_req++;
        end
        check("halt_req_count", n_req, 0);

        // ---- flush while a request is outstanding (4-cycle memory) ----
        mem_lat = 4;
        push_exp(1'b0, 16'h0000, 16'h0000);
        push_exp(1'b1, 16'h0011, rom[8'h10]);
        push_exp(1'b0, 16'h0000, 16'h0000);
        push_stream(16'h0040, 5);
        branch(16'h0010);
        check("unhalt", halted, 1'b0);
        n = 0;
        while (!(imem_req && imem_addr == 16'h0011) && n < 50) begin
            tick();
            n++;
        end
        check("req_0011_seen", (imem_req && imem_addr == 16'h0011), 1'b1);
        tick();
        check("wait_no_req", imem_req, 1'b0);
        branch(16'h0040);
        check("drain_no_req", imem_req, 1'b0);
        check("drain_bubble", if_id_valid, 1'b0);
        wait_req(20, "drain_req");
        check("drain_next_addr", imem_addr, 16'h0040);
        wait_done(300, "p2_done");
        check("p2_pc1", if_id_pc_plus1, 16'h0045);

        // ---- flush in the same cycle as an accept ----
        mem_lat = 1;
        push_exp(1'b0, 16'h0000, 16'h0000);
        push_stream(16'h0030, 4);
        branch(16'h0020);
        check("p3_req_addr", imem_addr, 16'h0020);
        tick();                       // word for 0x20 is on the bus now
        branch(16'h0030);
        check("p3_direct_req", imem_req, 1'b1);
        check("p3_direct_addr", imem_addr, 16'h0030);
        wait_done(200, "p3_done");
        check("p3_pc1", if_id_pc_plus1, 16'h0034);

        // ---- random latency and random stalls ----
        mem_lat = 0;
        rand_haz = 1'b1;
        for (int r = 0; r < 4; r++) begin
            s   = 16'($urandom_range(16'h80, 16'hC0));
            len = $urandom_range(3, 12);
            rom[8'(s + 16'(len))] = 16'hF000;
            push_exp(1'b0, 16'h0000, 16'h0000);
            push_stream(s, len + 1);
            branch(s);
            wait_done(3000, "rand_done");
            check("rand_pc1", if_id_pc_plus1, s + 16'(len) + 16'd1);
            rom[8'(s + 16'(len))] = rand_word();
        end
        rand_haz = 1'b0;
        pc_write = 1'b1; if_id_write = 1'b1;

        // ---- reset in the middle of a fetch ----
        mem_lat = 4;
        push_exp(1'b0, 16'h0000, 16'h0000);
        branch(16'h0050);
        tick();                       // WAIT, read outstanding
        rst_n = 1'b0;
        exp_q.delete();
        tick(); tick();
        check("mid_rst_valid", if_id_valid, 1'b0);
        check("mid_rst_halted", halted, 1'b0);
        check("mid_rst_addr", imem_addr, 16'h0000);
        rst_n = 1'b1;
        inj_valid = 1'b1;             // late word arriving during START
        inj_data  = 16'hBEEF;
        push_stream(16'h0000, 6);
        tick();
        inj_valid = 1'b0;
        check("restart_req", imem_req, 1'b1);
        check("restart_addr", imem_addr, 16'h0000);
        wait_done(300, "restart_done");
        check("restart_pc1", if_id_pc_plus1, 16'h0006);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
